// File: rtl/activation_writeback_if.sv
// Bundle-in / memory-write-out bus of the activation writeback stage.
interface activation_writeback_if #(
  parameter int NU_COUNT = 4,
  parameter int W        = 16,
  parameter int ADDR_W   = 8
);
  logic                         mac_valid;
  logic                         mac_ready;
  logic [NU_COUNT-1:0][W-1:0]   mac_data;
  logic [NU_COUNT-1:0]          ov_in;
  logic [1:0]                   act_sel;
  logic [ADDR_W-1:0]            base_addr;
  logic                         wr_en;
  logic [ADDR_W-1:0]            wr_addr;
  logic [W-1:0]                 wr_data;
  logic                         done;
  logic [15:0]                  ov_count;

  modport master (
    output mac_valid, mac_data, ov_in, act_sel, base_addr,
    input  mac_ready, wr_en, wr_addr, wr_data, done, ov_count
  );

  modport slave (
    input  mac_valid, mac_data, ov_in, act_sel, base_addr,
    output mac_ready, wr_en, wr_addr, wr_data, done, ov_count
  );
endinterface

// File: rtl/activation_writeback.sv
// Serializes one MAC result bundle through a two-stage activation pipeline
// into consecutive output-memory writes; counts MAC overflow events.
module activation_writeback #(
  parameter int NU_COUNT = 4,
  parameter int Q_INT    = 8,
  parameter int Q_FRAC   = 8,
  parameter int ADDR_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  activation_writeback_if.slave bus
);
  localparam int W   = Q_INT + Q_FRAC;
  localparam int K_W = (NU_COUNT > 1) ? $clog2(NU_COUNT) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(NU_COUNT - 1);
  localparam logic signed [W:0] ONE = {{W{1'b0}}, 1'b1} << Q_FRAC;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                      state;
  logic [K_W-1:0]              k;
  logic [NU_COUNT-1:0][W-1:0]  data_r;
  logic [1:0]                  sel_r;
  logic [ADDR_W-1:0]           base_r;
  logic [15:0]                 ov_count_r;
  logic                        accept;

  logic                        vld_p1, last_p1;
  logic signed [W-1:0]         act_p1;
  logic [ADDR_W-1:0]           addr_p1;

  logic                        wr_en_p2, done_p2;
  logic [ADDR_W-1:0]           wr_addr_p2;
  logic [W-1:0]                wr_data_p2;

  function automatic logic signed [W-1:0] sat_clamp(input logic signed [W:0] t,
                                                    input logic signed [W:0] lo,
                                                    input logic signed [W:0] hi);
    logic signed [W:0] r;
    if (t < lo)      r = lo;
    else if (t > hi) r = hi;
    else             r = t;
    return r[W-1:0];
  endfunction

  function automatic logic [15:0] sat_count(input logic [16:0] s);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [16:0] popcount(input logic [NU_COUNT-1:0] v);
    logic [16:0] c;
    c = '0;
    for (int i = 0; i < NU_COUNT; i++) c = c + 17'(v[i]);
    return c;
  endfunction

  // Sigmoid slope/offset evaluated one bit wider so the offset add cannot wrap.
  function automatic logic signed [W-1:0] activate(input logic signed [W-1:0] x,
                                                   input logic [1:0] sel);
    logic signed [W:0]   xe;
    logic signed [W:0]   t;
    logic signed [W-1:0] y;
    xe = {x[W-1], x};
    t  = (xe >>> 2) + (ONE >>> 1);
    case (sel)
      2'd0:    y = x;
      2'd1:    y = x[W-1] ? '0 : x;
      2'd2:    y = sat_clamp(t, '0, ONE);
      default: y = sat_clamp(xe, -ONE, ONE);
    endcase
    return y;
  endfunction

  assign bus.mac_ready = (state == IDLE) && !reset;
  assign accept        = bus.mac_valid && bus.mac_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      k          <= '0;
      vld_p1     <= 1'b0;
      last_p1    <= 1'b0;
      ov_count_r <= '0;
    end else begin
      vld_p1  <= (state == ISSUE);
      last_p1 <= (state == ISSUE) && (k == K_LAST);
      case (state)
        IDLE: if (accept) begin
          state      <= ISSUE;
          k          <= '0;
          ov_count_r <= sat_count({1'b0, ov_count_r} + popcount(bus.ov_in));
        end
        ISSUE: begin
          if (k == K_LAST) begin
            state <= DRAIN;
            k     <= '0;
          end else begin
            k <= k + 1'b1;
          end
        end
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      data_r <= bus.mac_data;
      sel_r  <= bus.act_sel;
      base_r <= bus.base_addr;
    end
  end

  // Stage 1: activation and address of element k
  always_ff @(posedge clk) begin
    act_p1  <= activate(data_r[k], sel_r);
    addr_p1 <= base_r + ADDR_W'(k);
  end

  // Stage 2: memory write port
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_p2   <= 1'b0;
      done_p2    <= 1'b0;
      wr_addr_p2 <= '0;
      wr_data_p2 <= '0;
    end else begin
      wr_en_p2 <= vld_p1;
      done_p2  <= vld_p1 && last_p1;
      if (vld_p1) begin
        wr_addr_p2 <= addr_p1;
        wr_data_p2 <= act_p1;
      end
    end
  end

  assign bus.wr_en    = wr_en_p2;
  assign bus.done     = done_p2;
  assign bus.wr_addr  = wr_addr_p2;
  assign bus.wr_data  = wr_data_p2;
  assign bus.ov_count = ov_count_r;
endmodule

// File: tb/tb_activation_writeback.sv
// Bench for activation_writeback: vector table plus scoreboard of expected writes.
module tb_activation_writeback;
  localparam int NU = 4;
  localparam int W  = 16;
  localparam int AW = 8;

  typedef logic [NU-1:0][W-1:0] bundle_t;
  typedef struct {
    logic [1:0]    sel;
    logic [AW-1:0] base;
    bundle_t       data;
    logic [NU-1:0] ov;
    bundle_t       exp;
  } vec_t;
  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    logic          last;
    int            cyc;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   ov_model = 0;
  wr_t  q[$];
  vec_t vecs[7];

  activation_writeback_if #(.NU_COUNT(NU), .W(W), .ADDR_W(AW)) bus ();

  activation_writeback #(.NU_COUNT(NU), .Q_INT(8), .Q_FRAC(8), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t limit=200000", $time);
    $fatal(1, "watchdog");
  end

  function automatic bundle_t pk(input logic [W-1:0] a0, input logic [W-1:0] a1,
                                 input logic [W-1:0] a2, input logic [W-1:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.wr_en === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_wr_en", {31'b0, bus.wr_en}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("wr_addr", {24'b0, bus.wr_addr}, {24'b0, e.addr});
          chk("wr_data", {16'b0, bus.wr_data}, {16'b0, e.data});
          chk("done_with_wr", {31'b0, bus.done}, {31'b0, e.last});
          chk("wr_cycle", cyc, e.cyc);
        end
      end else if (bus.done === 1'b1) begin
        chk("stray_done", {31'b0, bus.done}, 32'd0);
      end
    end
  endtask

  task automatic expect_bundle(input vec_t v, input int acc);
    wr_t e;
    for (int i = 0; i < NU; i++) begin
      e.addr = v.base + AW'(i);
      e.data = v.exp[i];
      e.last = (i == NU - 1);
      e.cyc  = acc + 2 + i;
      q.push_back(e);
    end
    ov_model = ov_model + $countones(v.ov);
    if (ov_model > 65535) ov_model = 65535;
  endtask

  task automatic load(input vec_t v);
    bus.mac_valid = 1'b1;
    bus.mac_data  = v.data;
    bus.ov_in     = v.ov;
    bus.act_sel   = v.sel;
    bus.base_addr = v.base;
  endtask

  task automatic send(input vec_t v, input bit keep_valid, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    load(v);
    while (!bus.mac_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_accept", {31'b0, bus.mac_ready}, 32'd1);
    @(posedge clk);
    #1;
    acc = cyc;
    expect_bundle(v, acc);
    if (!keep_valid) bus.mac_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", q.size(), 32'd0);
    q.delete();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    q.delete();
    ov_model = 0;
    repeat (2) @(negedge clk);
    chk("ready_in_reset", {31'b0, bus.mac_ready}, 32'd0);
    chk("ov_count_reset", {16'b0, bus.ov_count}, 32'd0);
    chk("wr_en_reset", {31'b0, bus.wr_en}, 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", {31'b0, bus.mac_ready}, 32'd1);
  endtask

  initial begin
    int acc, a1, a2;
    vec_t b1, b2;

    bus.mac_valid = 1'b0;
    bus.mac_data  = '0;
    bus.ov_in     = '0;
    bus.act_sel   = '0;
    bus.base_addr = '0;

    vecs[0] = '{sel: 2'd1, base: 8'h10, data: pk(16'h0180, 16'hFF00, 16'h0000, 16'h7FFF),
                ov: 4'b0001, exp: pk(16'h0180, 16'h0000, 16'h0000, 16'h7FFF)};
    vecs[1] = '{sel: 2'd2, base: 8'h30, data: pk(16'h0000, 16'h0100, 16'h0400, 16'hF800),
                ov: 4'b0000, exp: pk(16'h0080, 16'h00C0, 16'h0100, 16'h0000)};
    vecs[2] = '{sel: 2'd3, base: 8'h40, data: pk(16'h0080, 16'h0300, 16'hFE00, 16'hFF80),
                ov: 4'b1111, exp: pk(16'h0080, 16'h0100, 16'hFF00, 16'hFF80)};
    vecs[3] = '{sel: 2'd0, base: 8'h50, data: pk(16'h0080, 16'h0300, 16'hFE00, 16'hFF80),
                ov: 4'b0010, exp: pk(16'h0080, 16'h0300, 16'hFE00, 16'hFF80)};
    vecs[4] = '{sel: 2'd0, base: 8'hFE, data: pk(16'h1234, 16'h8000, 16'h7FFF, 16'hFFFF),
                ov: 4'b0100, exp: pk(16'h1234, 16'h8000, 16'h7FFF, 16'hFFFF)};
    vecs[5] = '{sel: 2'd3, base: 8'h60, data: pk(16'h0100, 16'hFF00, 16'h8000, 16'h7FFF),
                ov: 4'b0000, exp: pk(16'h0100, 16'hFF00, 16'hFF00, 16'h0100)};
    vecs[6] = '{sel: 2'd2, base: 8'h70, data: pk(16'hFE00, 16'h7FFF, 16'hFF00, 16'h0200),
                ov: 4'b1000, exp: pk(16'h0000, 16'h0100, 16'h0040, 16'h0100)};

    fork
      monitor();
    join_none

    // Power-on reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", {31'b0, bus.wr_en}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_wr_addr", {24'b0, bus.wr_addr}, 32'd0);
    chk("rst_wr_data", {16'b0, bus.wr_data}, 32'd0);
    chk("rst_ov_count", {16'b0, bus.ov_count}, 32'd0);
    chk("rst_ready", {31'b0, bus.mac_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ready_first_cycle", {31'b0, bus.mac_ready}, 32'd1);

    for (int i = 0; i < 7; i++) begin
      send(vecs[i], 1'b0, acc);
      drain();
    end
    chk("ov_count_table", {16'b0, bus.ov_count}, ov_model);

    // Back-to-back bundles with mac_valid held high
    do_reset();
    b1 = vecs[0];
    b1.ov = 4'b1011;
    b2 = vecs[2];
    b2.ov = 4'b0001;
    send(b1, 1'b1, a1);
    @(negedge clk);
    load(b2);
    for (int j = 0; j < 5; j++) begin
      chk("busy_ready", {31'b0, bus.mac_ready}, 32'd0);
      @(negedge clk);
    end
    chk("ready_again", {31'b0, bus.mac_ready}, 32'd1);
    @(posedge clk);
    #1;
    a2 = cyc;
    expect_bundle(b2, a2);
    bus.mac_valid = 1'b0;
    chk("b2b_spacing", a2 - a1, 32'd6);
    drain();
    chk("ov_count_b2b", {16'b0, bus.ov_count}, 32'd4);

    // Reset in the cycle after the second write
    b1 = vecs[0];
    b1.base = 8'h20;
    b1.ov = 4'b0110;
    send(b1, 1'b0, acc);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pops_before_reset", q.size(), 32'd2);
    reset = 1'b1;
    q.delete();
    ov_model = 0;
    repeat (2) @(negedge clk);
    chk("ov_count_mid_reset", {16'b0, bus.ov_count}, 32'd0);
    chk("ready_mid_reset", {31'b0, bus.mac_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_mid_reset", {31'b0, bus.mac_ready}, 32'd1);
    repeat (4) @(negedge clk);

    send(vecs[6], 1'b0, acc);
    drain();
    chk("ov_count_after_reset", {16'b0, bus.ov_count}, ov_model);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/activation_writeback.md
# activation_writeback

Downstream stage of the MAC array. Accepts one bundle of NU_COUNT saturated fixed-point accumulator results and serializes them through a two-stage pipelined activation function. Writes each activated value to the layer-output memory at consecutive addresses and keeps a saturating count of MAC overflow events for debug.

## Interface
Parameters:
- NU_COUNT, 4, number of MAC units (elements per bundle)
- Q_INT, 8, integer bits incl. sign (must be ≥ 2)
- Q_FRAC, 8, fraction bits; W = Q_INT+Q_FRAC
- ADDR_W, 8, output-memory address width

Ports (one clock, clk; reset is synchronous and active-high, named reset):
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- mac_valid  in  1  bundle on mac_data valid
- mac_ready  out  1  block can accept a bundle
- mac_data  in  NU_COUNT×W  packed two's-complement bundle; element i at slice [i]
- ov_in  in  NU_COUNT  per-element MAC overflow flag (pos OR neg, product or sum)
- act_sel  in  2  0 identity, 1 ReLU, 2 hard sigmoid, 3 hard tanh
- base_addr  in  ADDR_W  write address of element 0
- wr_en  out  1  memory write strobe
- wr_addr  out  ADDR_W  write address
- wr_data  out  W  activated value
- done  out  1  one-cycle pulse with the bundle's last write
- ov_count  out  16  saturating count of overflow-flagged elements

## Operation
- FSM: IDLE, ISSUE, DRAIN. mac_ready = (state==IDLE) && !reset.
- IDLE: on mac_valid && mac_ready, latch mac_data, act_sel, base_addr; k←0; go ISSUE. ov_count += popcount(ov_in), saturating at 0xFFFF.
- ISSUE: element k enters stage 1 (activation, registered); k increments each cycle; after k = NU_COUNT-1 go DRAIN.
- DRAIN: stage 2 emits the final write; done=1; go IDLE.
- Stage 2 registers wr_en/wr_addr/wr_data; wr_addr = base_addr + k mod 2^ADDR_W (wraps 0xFF→0x00 at ADDR_W=8).
- Activation (ONE = 1<<Q_FRAC):
  - identity: y = x
  - ReLU: y = x<0 ? 0 : x
  - hard sigmoid: t = (x>>>2) + (ONE>>1), computed in W+1 bits; y = clamp(t, 0, ONE)
  - hard tanh: y = clamp(x, -ONE, ONE)
- Overflow-flagged elements are processed normally; ov_in only feeds ov_count.
- Inputs other than mac_valid are ignored outside the accept cycle.

## Timing
- Reset (sync): state IDLE, k=0, wr_en=0, wr_addr=0, wr_data=0, done=0, ov_count=0, pipeline contents discarded; mac_ready=0 while reset high, 1 in first cycle after.
- Accept at edge T → wr_en high cycles T+2 … T+NU_COUNT+1, one element per cycle, element order 0…NU_COUNT-1, no gaps.
- done high only in cycle T+NU_COUNT+1 (coincident with last wr_en).
- mac_ready low cycles T+1 … T+NU_COUNT+1; next accept earliest at edge T+NU_COUNT+2 (busy NU_COUNT+1 cycles per bundle).
- mac_valid held high continuously: bundles accepted back-to-back at that rate; no bundle lost or duplicated.
- Reset asserted mid-bundle: no further wr_en/done after the reset edge; remaining elements dropped.
- ov_count at 0xFFFF stays at 0xFFFF.

## Test plan
- ReLU, base 0x10, data {0x0180, 0xFF00, 0x0000, 0x7FFF} → writes (0x10,0x0180) (0x11,0x0000) (0x12,0x0000) (0x13,0x7FFF) in cycles T+2..T+5; done only at T+5.
- Hard sigmoid, data {0x0000, 0x0100, 0x0400, 0xF800} → {0x0080, 0x00C0, 0x0100, 0x0000}.
- Hard tanh, data {0x0080, 0x0300, 0xFE00, 0xFF80} → {0x0080, 0x0100, 0xFF00, 0xFF80}; identity on the same data → unchanged.
- Wrap: identity, base 0xFE → addresses 0xFE, 0xFF, 0x00, 0x01.
- Back-to-back: mac_valid held high, two bundles with ov_in 4'b1011 then 4'b0001 → second accept at T+6, 8 contiguous-per-bundle writes, two done pulses, ov_count = 4, mac_ready low in busy cycles.
- Reset mid-op: assert reset in cycle after second wr_en → no more writes/done, ov_count = 0, mac_ready = 1 first cycle after reset deasserts; new bundle then processes correctly.
